prog_loader: RTL and testbench

- Writer side of the instruction-memory interface. The processor's datapath only reads instruction memory.
- Receives a byte stream (count, program words, checksum) over a valid/ready handshake and writes 16-bit instruction words into instmem starting at address 0.
- Holds the computer in reset while loading. Releases it only after a verified load.

---
 rtl/prog_loader.sv | 158 +++++++++++++++
 tb/tb_prog_loader.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
`default_nettype none
// ============================================================================
// Module   : prog_loader
// Brief    : Byte-stream instruction-memory loader; holds the CPU in reset
//            until a count/words/checksum stream has been written and verified.
// Revision : 1.0 - initial release
// ============================================================================
module prog_loader #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 16
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              start,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [DATA_W-1:0] im_wdata,
    output logic              cpu_reset,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam int         c_IDX_W = ADDR_W + 1;
    localparam logic [8:0] c_MAX_N = 9'(2 ** ADDR_W);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_GET_CNT = 3'd1,
        S_GET_HI  = 3'd2,
        S_GET_LO  = 3'd3,
        S_WRITE   = 3'd4,
        S_GET_SUM = 3'd5,
        S_DONE    = 3'd6,
        S_ERR     = 3'd7
    } state_t;

    state_t              r_state;
    state_t              w_nxt;
    logic                r_in_ready;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic                r_cpu_reset;
    logic                r_busy;
    logic                r_done;
    logic                r_error;
    logic [c_IDX_W-1:0]  r_cnt;
    logic [c_IDX_W-1:0]  r_idx;
    logic [7:0]          r_sum;
    logic [7:0]          r_hi;
    logic                w_take;
    logic                w_restart;
    logic                w_nxt_rx;

    assign w_take    = in_valid & r_in_ready;
    assign w_restart = start & ((r_state == S_IDLE) | (r_state == S_DONE) | (r_state == S_ERR));
    assign w_nxt_rx  = (w_nxt == S_GET_CNT) | (w_nxt == S_GET_HI) |
                       (w_nxt == S_GET_LO)  | (w_nxt == S_GET_SUM);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nxt;
        end
    end

    always_comb begin
        w_nxt = r_state;
        case (r_state)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) w_nxt = S_GET_CNT;
            end
            S_GET_CNT: begin
                if (w_take) begin
                    if ((in_data == 8'd0) || ({1'b0, in_data} > c_MAX_N)) w_nxt = S_ERR;
                    else                                                   w_nxt = S_GET_HI;
                end
            end
            S_GET_HI: begin
                if (w_take) w_nxt = S_GET_LO;
            end
            S_GET_LO: begin
                if (w_take) w_nxt = S_WRITE;
            end
            // Index was already advanced on the low-byte edge
            S_WRITE: begin
                w_nxt = (r_idx < r_cnt) ? S_GET_HI : S_GET_SUM;
            end
            S_GET_SUM: begin
                if (w_take) w_nxt = (in_data == r_sum) ? S_DONE : S_ERR;
            end
            default: w_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_in_ready  <= 1'b0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_cpu_reset <= 1'b1;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
            r_cnt       <= '0;
            r_idx       <= '0;
            r_sum       <= '0;
            r_hi        <= '0;
        end else begin
            r_we        <= 1'b0;
            r_in_ready  <= w_nxt_rx;
            r_busy      <= w_nxt_rx | (w_nxt == S_WRITE);
            r_done      <= (w_nxt == S_DONE);
            r_error     <= (w_nxt == S_ERR);
            r_cpu_reset <= (w_nxt != S_DONE);

            if (w_restart) begin
                r_idx <= '0;
                r_sum <= '0;
            end

            if (w_take) begin
                case (r_state)
                    S_GET_CNT: r_cnt <= c_IDX_W'(in_data);
                    S_GET_HI: begin
                        r_hi  <= in_data;
                        r_sum <= r_sum + in_data;
                    end
                    S_GET_LO: begin
                        r_we    <= 1'b1;
                        r_addr  <= r_idx[ADDR_W-1:0];
                        r_wdata <= DATA_W'({r_hi, in_data});
                        r_idx   <= r_idx + 1'b1;
                        r_sum   <= r_sum + in_data;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign in_ready  = r_in_ready;
    assign im_we     = r_we;
    assign im_addr   = r_addr;
    assign im_wdata  = r_wdata;
    assign cpu_reset = r_cpu_reset;
    assign busy      = r_busy;
    assign done      = r_done;
    assign error     = r_error;

endmodule
`default_nettype wire

// File: tb/tb_prog_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_prog_loader
// Brief    : Self-checking bench for prog_loader against a stream-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_prog_loader;

    localparam int ADDR_W = 3;
    localparam int DATA_W = 16;

    typedef logic [7:0]  bq_t[$];
    typedef logic [31:0] wq_t[$];

    logic              CLK = 1'b0;
    logic              RESET;
    logic              start;
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_ready;
    logic              im_we;
    logic [ADDR_W-1:0] im_addr;
    logic [DATA_W-1:0] im_wdata;
    logic              cpu_reset;
    logic              busy;
    logic              done;
    logic              error;

    int  n_checks = 0;
    int  n_pass   = 0;
    wq_t wq;

    prog_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .CLK(CLK), .RESET(RESET), .start(start), .in_data(in_data),
        .in_valid(in_valid), .in_ready(in_ready), .im_we(im_we),
        .im_addr(im_addr), .im_wdata(im_wdata), .cpu_reset(cpu_reset),
        .busy(busy), .done(done), .error(error)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Write capture; the bubble cycle must coincide with each write
    always @(negedge CLK) begin
        if (im_we === 1'b1) begin
            wq.push_back(32'({im_addr, im_wdata}));
            chk("ready_low_on_write", 32'(in_ready), 32'd0);
        end
    end

    // Stream-level reference: what a correct loader must write and report
    task automatic model(input bq_t b, output wq_t w, output logic good);
        int         n;
        logic [7:0] sum;
        w    = {};
        good = 1'b0;
        n    = int'(b[0]);
        if (n == 0 || n > (1 << ADDR_W)) return;
        sum = 8'd0;
        for (int i = 0; i < n; i++) begin
            sum = sum + b[1 + 2*i] + b[2 + 2*i];
            w.push_back((i << 16) | {16'd0, b[1 + 2*i], b[2 + 2*i]});
        end
        good = (b[2*n + 1] == sum);
    endtask

    task automatic cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cycle();
        start = 1'b0;
    endtask

    task automatic send(input bq_t b, input bit gaps, input int count);
        logic rdy;
        int   t;
        for (int i = 0; i < count; i++) begin
            if (gaps && $urandom_range(0, 1) == 1) begin
                in_valid = 1'b0;
                in_data  = 8'($urandom);
                repeat ($urandom_range(1, 2)) cycle();
            end
            in_valid = 1'b1;
            in_data  = b[i];
            t = 0;
            forever begin
                @(negedge CLK);
                rdy = in_ready;
                cycle();
                if (rdy) break;
                t++;
                if (t > 40) begin
                    chk("accept_timeout", 32'd1, 32'd0);
                    in_valid = 1'b0;
                    return;
                end
            end
        end
        in_valid = 1'b0;
        in_data  = 8'($urandom);
    endtask

    task automatic run_case(input string tag, input bq_t b, input bit gaps);
        wq_t  ew;
        logic good;
        int   len;
        model(b, ew, good);
        len = (ew.size() == 0) ? 1 : 2 * ew.size() + 2;
        wq.delete();
        pulse_start();
        chk({tag, ":busy_start"}, 32'(busy), 32'd1);
        chk({tag, ":done_clr"},   32'(done), 32'd0);
        chk({tag, ":cpurst_start"}, 32'(cpu_reset), 32'd1);
        send(b, gaps, len);
        chk({tag, ":done"},   32'(done),      32'(good));
        chk({tag, ":error"},  32'(error),     32'(!good));
        chk({tag, ":cpurst"}, 32'(cpu_reset), 32'(!good));
        chk({tag, ":busy"},   32'(busy),      32'd0);
        repeat (3) cycle();
        chk({tag, ":nwrites"}, 32'(wq.size()), 32'(ew.size()));
        for (int i = 0; i < ew.size() && i < wq.size(); i++)
            chk({tag, ":write"}, wq[i], ew[i]);
    endtask

    bq_t good_s, bad_s, s;
    logic [7:0] sum;

    initial begin
        RESET = 1'b1; start = 1'b0; in_data = 8'h00; in_valid = 1'b0;
        repeat (2) cycle();
        chk("rst:in_ready", 32'(in_ready), 32'd0);
        chk("rst:im_we",    32'(im_we),    32'd0);
        chk("rst:im_addr",  32'(im_addr),  32'd0);
        chk("rst:im_wdata", 32'(im_wdata), 32'd0);
        chk("rst:cpu_reset", 32'(cpu_reset), 32'd1);
        chk("rst:busy",  32'(busy),  32'd0);
        chk("rst:done",  32'(done),  32'd0);
        chk("rst:error", 32'(error), 32'd0);
        RESET = 1'b0;
        cycle();

        good_s = '{8'h03, 8'h98, 8'hC3, 8'h99, 8'h06, 8'h40, 8'h1C, 8'h56};
        bad_s  = '{8'h03, 8'h98, 8'hC3, 8'h99, 8'h06, 8'h40, 8'h1C, 8'h57};
        run_case("good", good_s, 1'b0);
        run_case("badsum", bad_s, 1'b0);
        run_case("cnt0", '{8'h00}, 1'b0);
        run_case("cnt9", '{8'h09}, 1'b0);

        s = '{8'h08};
        sum = 8'd0;
        for (int i = 0; i < 16; i++) begin
            s.push_back(8'($urandom));
            sum = sum + s[i + 1];
        end
        s.push_back(sum);
        run_case("cnt8", s, 1'b0);

        run_case("gaps", good_s, 1'b1);

        // Abort after the 99 byte
        wq.delete();
        pulse_start();
        s = '{8'h03, 8'h98, 8'hC3, 8'h99};
        send(s, 1'b0, 4);
        RESET = 1'b1;
        cycle();
        chk("midrst:in_ready", 32'(in_ready), 32'd0);
        chk("midrst:im_we", 32'(im_we), 32'd0);
        chk("midrst:cpu_reset", 32'(cpu_reset), 32'd1);
        chk("midrst:done", 32'(done), 32'd0);
        chk("midrst:error", 32'(error), 32'd0);
        chk("midrst:busy", 32'(busy), 32'd0);
        RESET = 1'b0;
        repeat (2) cycle();
        chk("midrst:nwrites", 32'(wq.size()), 32'd1);
        run_case("after_rst", good_s, 1'b1);

        // Still DONE from previous case: restart must drop done at once
        run_case("restart", '{8'h01, 8'h00, 8'h00, 8'h00}, 1'b0);

        for (int k = 0; k < 6; k++) begin
            int n;
            n = $urandom_range(0, 10);
            s = '{8'(n)};
            sum = 8'd0;
            if (n >= 1 && n <= 8) begin
                for (int i = 0; i < 2 * n; i++) begin
                    s.push_back(8'($urandom));
                    sum = sum + s[i + 1];
                end
                s.push_back(($urandom_range(0, 1) == 1) ? sum : 8'(sum + 8'($urandom_range(1, 255))));
            end
            run_case("rand", s, 1'b1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
